// File: rtl/ac_config_seq.sv
// Audio codec configuration sequencer: writes an 11-entry register table to the codec over an Avalon-MM i2cMaster.
// Latency: powerup delay of ceil(CLK_MASTER_FRQ/1e6*PWRUP_DELAY_US) cycles, then 4 write cycles + 2 per poll + 1 per entry.
// Backpressure: waits on the i2cMaster busy flag by polling; the optional AC_CONFIG_RETRY_EN macro enables retries of NACKed entries.
module ac_config_seq #(
    parameter int         CLK_MASTER_FRQ = 50_000_000,
    parameter int         PWRUP_DELAY_US = 1000,
    parameter logic [7:0] DEV_ADR        = 8'h34,
    parameter string      INTERFACE_TYPE = "LEFT-JUSTIFIED",
    parameter int         DATA_WDT       = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] errIdx,
    output logic [1:0] avmAdr,
    output logic       avmWr,
    output logic [7:0] avmWrData,
    output logic       avmRd,
    input  logic [7:0] avmRdData
);

    localparam logic [63:0] DLY_PROD = 64'(CLK_MASTER_FRQ) * 64'(PWRUP_DELAY_US);
    localparam logic [63:0] DLY_CYC  = (DLY_PROD + 64'd999_999) / 64'd1_000_000;
    // Counter terminal value; at least one powerup cycle is always spent.
    localparam logic [31:0] DLY_LAST = (DLY_CYC > 64'd1) ? 32'(DLY_CYC - 64'd1) : 32'd0;

    localparam logic [1:0] FORMAT = (INTERFACE_TYPE == "I2S")             ? 2'b10 :
                                    (INTERFACE_TYPE == "RIGHT-JUSTIFIED") ? 2'b00 : 2'b01;
    localparam logic [1:0] IWL    = (DATA_WDT == 16) ? 2'b00 :
                                    (DATA_WDT == 20) ? 2'b01 :
                                    (DATA_WDT == 32) ? 2'b11 : 2'b10;
    localparam logic [8:0] FMT        = {5'd0, IWL, FORMAT};
    localparam logic [3:0] LAST_ENTRY = 4'd10;

    typedef enum logic [3:0] {
        IDLE, WAIT_PWR, LD_DEV, LD_HI, LD_LO, GO, POLL_RD, POLL_CHK, NEXT, ERROR, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  entry_idx, entry_nxt;
    logic [31:0] dly_cnt, dly_nxt;
    logic [3:0]  err_idx_nxt;
    logic        wr_nxt, rd_nxt;
    logic [1:0]  adr_nxt;
    logic [7:0]  dat_nxt;
    logic [15:0] rom_q;
    logic        unused_rd;

    assign unused_rd = ^avmRdData[7:2];

`ifdef AC_CONFIG_RETRY_EN
    logic [1:0] retry_cnt, retry_nxt;
`endif

    // Register table {reg[6:0], val[8:0]}; byte high is word[15:8], byte low word[7:0].
    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = {7'd15, 9'h000};
            4'd1:    w = {7'd0,  9'h017};
            4'd2:    w = {7'd1,  9'h017};
            4'd3:    w = {7'd2,  9'h079};
            4'd4:    w = {7'd3,  9'h079};
            4'd5:    w = {7'd4,  9'h012};
            4'd6:    w = {7'd5,  9'h000};
            4'd7:    w = {7'd6,  9'h002};
            4'd8:    w = {7'd7,  FMT};
            4'd9:    w = {7'd8,  9'h000};
            4'd10:   w = {7'd9,  9'h001};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state, entry index, powerup counter and error index.
    always_comb begin
        state_nxt   = state;
        entry_nxt   = entry_idx;
        dly_nxt     = dly_cnt;
        err_idx_nxt = errIdx;
`ifdef AC_CONFIG_RETRY_EN
        retry_nxt   = retry_cnt;
`endif
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt   = WAIT_PWR;
                    entry_nxt   = 4'd0;
                    dly_nxt     = 32'd0;
                    err_idx_nxt = 4'd0;
`ifdef AC_CONFIG_RETRY_EN
                    retry_nxt   = 2'd0;
`endif
                end
            end
            WAIT_PWR: begin
                if (dly_cnt >= DLY_LAST) begin
                    state_nxt = LD_DEV;
                    dly_nxt   = 32'd0;
                end else begin
                    dly_nxt = dly_cnt + 32'd1;
                end
            end
            LD_DEV:  state_nxt = LD_HI;
            LD_HI:   state_nxt = LD_LO;
            LD_LO:   state_nxt = GO;
            GO:      state_nxt = POLL_RD;
            POLL_RD: state_nxt = POLL_CHK;
            POLL_CHK: begin
                if (avmRdData[0]) begin
                    state_nxt = POLL_RD;
                end else if (avmRdData[1]) begin
`ifdef AC_CONFIG_RETRY_EN
                    if (retry_cnt == 2'd3) begin
                        state_nxt   = ERROR;
                        err_idx_nxt = entry_idx;
                    end else begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = LD_DEV;
                    end
`else
                    state_nxt   = ERROR;
                    err_idx_nxt = entry_idx;
`endif
                end else begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
`ifdef AC_CONFIG_RETRY_EN
                retry_nxt = 2'd0;
`endif
                // The >= also catches a corrupted index and ends the sequence cleanly.
                if (entry_idx >= LAST_ENTRY) begin
                    state_nxt = DONE;
                end else begin
                    entry_nxt = entry_idx + 4'd1;
                    state_nxt = LD_DEV;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus access decode for the state being entered, so outputs register in step with the state.
    always_comb begin
        rom_q   = rom_word(entry_nxt);
        wr_nxt  = 1'b0;
        rd_nxt  = 1'b0;
        adr_nxt = 2'd0;
        dat_nxt = 8'h00;
        case (state_nxt)
            LD_DEV:  begin wr_nxt = 1'b1; adr_nxt = 2'd0; dat_nxt = DEV_ADR;      end
            LD_HI:   begin wr_nxt = 1'b1; adr_nxt = 2'd1; dat_nxt = rom_q[15:8];  end
            LD_LO:   begin wr_nxt = 1'b1; adr_nxt = 2'd2; dat_nxt = rom_q[7:0];   end
            GO:      begin wr_nxt = 1'b1; adr_nxt = 2'd3; dat_nxt = 8'h01;        end
            POLL_RD: begin rd_nxt = 1'b1; adr_nxt = 2'd3;                         end
            default: ;
        endcase
    end

    // State and registered outputs; reset restarts the powerup wait with a quiet bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_PWR;
            entry_idx <= 4'd0;
            dly_cnt   <= 32'd0;
            errIdx    <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            avmWr     <= 1'b0;
            avmRd     <= 1'b0;
            avmAdr    <= 2'd0;
            avmWrData <= 8'h00;
        end else begin
            state     <= state_nxt;
            entry_idx <= entry_nxt;
            dly_cnt   <= dly_nxt;
            errIdx    <= err_idx_nxt;
            busy      <= (state_nxt != IDLE) && (state_nxt != DONE) && (state_nxt != ERROR);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERROR);
            avmWr     <= wr_nxt;
            avmRd     <= rd_nxt;
            avmAdr    <= adr_nxt;
            avmWrData <= dat_nxt;
        end
    end

`ifdef AC_CONFIG_RETRY_EN
    // Attempts made on the current entry beyond the first.
    always_ff @(posedge clk) begin
        if (reset) retry_cnt <= 2'd0;
        else       retry_cnt <= retry_nxt;
    end
`endif

endmodule

// File: tb/tb_ac_config_seq.sv
// Bench for ac_config_seq: spec-level transaction model plus a scripted i2cMaster slave.
// Latency: every DUT cycle is compared once against the model while checking is enabled.
// Backpressure: slave busy polls and NACKs come from per-GO plan arrays.
module tb_ac_config_seq;

    localparam int TB_FRQ = 50_000_000;
    localparam int TB_US  = 2;
    localparam int DLY    = (TB_FRQ / 1000 * TB_US + 999) / 1000;
`ifdef AC_CONFIG_RETRY_EN
    localparam int MAX_ATT = 4;
`else
    localparam int MAX_ATT = 1;
`endif

    logic       clk, reset, start;
    logic       busy, done, error, avmWr, avmRd;
    logic [3:0] errIdx;
    logic [1:0] avmAdr;
    logic [7:0] avmWrData, rd_data;
    logic       i_busy, i_done, i_error, i_wr, i_rd;
    logic [3:0] i_err_idx;
    logic [1:0] i_adr;
    logic [7:0] i_wdat;
    logic [18:0] dut_vec;

    ac_config_seq #(.CLK_MASTER_FRQ(TB_FRQ), .PWRUP_DELAY_US(TB_US)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
        .errIdx(errIdx), .avmAdr(avmAdr), .avmWr(avmWr), .avmWrData(avmWrData),
        .avmRd(avmRd), .avmRdData(rd_data));

    ac_config_seq #(.CLK_MASTER_FRQ(TB_FRQ), .PWRUP_DELAY_US(TB_US),
                    .INTERFACE_TYPE("I2S"), .DATA_WDT(16)) u_i2s (
        .clk(clk), .reset(reset), .start(start), .busy(i_busy), .done(i_done), .error(i_error),
        .errIdx(i_err_idx), .avmAdr(i_adr), .avmWr(i_wr), .avmWrData(i_wdat),
        .avmRd(i_rd), .avmRdData(8'h00));

    assign dut_vec = {busy, done, error, errIdx, avmWr, avmRd, avmAdr, avmWrData};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  bp[64];
    bit  nk[64];
    bit  slv_clr, mon_clr, chk_on;
    int  total, bad, cyc;
    logic [18:0] exp_q[$];

    // Slave: each GO loads a busy-poll count and NACK flag from the plan; reads answer next cycle.
    int go_cnt, poll_left;
    bit cur_nack;
    always @(posedge clk) begin
        if (slv_clr) go_cnt <= 0;
        else if (avmWr && avmAdr == 2'd3 && go_cnt < 64) begin
            poll_left <= bp[go_cnt];
            cur_nack  <= nk[go_cnt];
            go_cnt    <= go_cnt + 1;
        end
        if (avmRd) begin
            if (poll_left > 0) begin
                rd_data   <= 8'hA9;
                poll_left <= poll_left - 1;
            end else begin
                rd_data <= {6'b101010, cur_nack, 1'b0};
            end
        end
    end

    // Bus monitor: access counts and the entry-8 bytes of both instances.
    int n_dwr, n_go, n_rd, n_hi, n_lo, n_ilo;
    logic [7:0] e8_hi, e8_lo, i2s_lo8;
    always @(posedge clk) begin
        if (mon_clr) begin
            n_dwr = 0; n_go = 0; n_rd = 0; n_hi = 0; n_lo = 0;
            e8_hi = 8'h00; e8_lo = 8'h00;
        end else begin
            if (avmWr) begin
                if (avmAdr == 2'd3) n_go++; else n_dwr++;
                if (avmAdr == 2'd1) begin if (n_hi == 8) e8_hi = avmWrData; n_hi++; end
                if (avmAdr == 2'd2) begin if (n_lo == 8) e8_lo = avmWrData; n_lo++; end
            end
            if (avmRd) n_rd++;
        end
        if (i_wr && i_adr == 2'd2) begin
            if (n_ilo == 8) i2s_lo8 = i_wdat;
            n_ilo++;
        end
    end

    function automatic logic [8:0] fmt_of(input string it, input int w);
        int f, l;
        f = (it == "I2S") ? 2 : (it == "RIGHT-JUSTIFIED") ? 0 : 1;
        l = (w == 32) ? 3 : (w - 16) / 4;
        return 9'(l * 4 + f);
    endfunction

    // Codec register table from the datasheet-level description: {reg, val}.
    function automatic logic [15:0] entry_bytes(input int e);
        int r[11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        int v[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h002, 0, 'h000, 'h001};
        logic [8:0] val;
        val = (e == 8) ? fmt_of("LEFT-JUSTIFIED", 24) : 9'(v[e]);
        return {7'(r[e]), val};
    endfunction

    function automatic logic [18:0] v_idle();
        return {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'h00};
    endfunction
    function automatic logic [18:0] v_wr(input logic [1:0] a, input logic [7:0] d);
        return {1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, a, d};
    endfunction
    function automatic logic [18:0] v_rd();
        return {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd3, 8'h00};
    endfunction

    // Expected per-cycle outputs for one run, derived from the plan arrays.
    task automatic build(input bit from_reset);
        int g, att;
        bit fin, again;
        logic [15:0] eb;
        exp_q.delete();
        if (from_reset) exp_q.push_back(19'd0);
        repeat (from_reset ? DLY - 1 : DLY) exp_q.push_back(v_idle());
        g = 0;
        fin = 1'b0;
        for (int e = 0; e < 11 && !fin; e++) begin
            att = 0;
            eb = entry_bytes(e);
            do begin
                exp_q.push_back(v_wr(2'd0, 8'h34));
                exp_q.push_back(v_wr(2'd1, eb[15:8]));
                exp_q.push_back(v_wr(2'd2, eb[7:0]));
                exp_q.push_back(v_wr(2'd3, 8'h01));
                for (int p = 0; p <= bp[g]; p++) begin
                    exp_q.push_back(v_rd());
                    exp_q.push_back(v_idle());
                end
                again = 1'b0;
                if (nk[g]) begin
                    att++;
                    if (att < MAX_ATT) again = 1'b1;
                    else begin
                        exp_q.push_back({1'b0, 1'b0, 1'b1, 4'(e), 1'b0, 1'b0, 2'd0, 8'h00});
                        fin = 1'b1;
                    end
                end else begin
                    exp_q.push_back(v_idle());
                end
                g++;
            end while (again);
        end
        if (!fin) exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 8'h00});
    endtask

    // One clock: sample away from the edge and compare against the model.
    task automatic tick();
        logic [18:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (dut_vec !== e) begin
                bad++;
                $display("FAIL cycle %0d: dut=%h model=%h", cyc, dut_vec, e);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic run_out(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin tick(); n++; end
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL %s: model queue not drained, %0d cycles left", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic plan(input int bmax, input int nack_mode);
        for (int i = 0; i < 64; i++) begin
            bp[i] = (bmax < 0) ? -bmax : int'($urandom_range(0, bmax));
            nk[i] = (nack_mode == 0) ? 1'b0 : (nack_mode == 1) ? (i >= 4) : ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic do_start();
        slv_clr = 1'b1; mon_clr = 1'b1;
        build(1'b0);
        chk_on = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; slv_clr = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic reset_run(input string name);
        slv_clr = 1'b1; mon_clr = 1'b1;
        build(1'b1);
        chk_on = 1'b1;
        tick();
        reset = 1'b0; slv_clr = 1'b0; mon_clr = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0; bad = 0; cyc = 0; n_ilo = 0;
        reset = 1'b1; start = 1'b0; chk_on = 1'b0; slv_clr = 1'b1; mon_clr = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 32'(dut_vec), 32'd0);

        // Always-ack run straight out of reset.
        plan(0, 0);
        reset_run("s1");
        n = 0;
        while (n < 1000) begin tick(); n++; if (avmWr) break; end
        check("first_write_cycle", n, 100);
        run_out("s1", 2000);
        check("s1_done", done, 1);
        check("s1_busy", busy, 0);
        check("s1_data_writes", n_dwr, 33);
        check("s1_go_writes", n_go, 11);
        check("s1_reads", n_rd, 11);
        check("entry8_hi", e8_hi, 8'h0E);
        check("entry8_lo", e8_lo, 8'h09);
        check("i2s16_entry8_lo", i2s_lo8, 8'h02);

        // Five busy polls per entry, rerun from DONE, with an ignored start mid-run.
        plan(-5, 0);
        do_start();
        check("start_clears_done", done, 0);
        repeat (150) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_ignored_start", busy, 1);
        run_out("s2", 3000);
        check("s2_done", done, 1);
        check("s2_reads", n_rd, 66);
        check("s2_data_writes", n_dwr, 33);

        // Entry 4 always NACKs.
        plan(3, 1);
        do_start();
        run_out("s3", 3000);
        check("s3_error", error, 1);
        check("s3_err_idx", errIdx, 4);
        check("s3_busy", busy, 0);
        check("s3_go_writes", n_go, 4 + MAX_ATT);

        // Random busy/NACK patterns.
        for (int r = 0; r < 4; r++) begin
            plan(3, 2);
            do_start();
            run_out("random", 3000);
        end

        // Reset in the middle of polling.
        plan(-5, 0);
        do_start();
        n = 0;
        while (n < 1000) begin tick(); n++; if (avmRd) break; end
        check("reached_poll", avmRd, 1);
        chk_on = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        tick();
        check("midpoll_reset_outputs", 32'(dut_vec), 32'd0);
        tick();
        check("no_access_in_reset", {avmWr, avmRd}, 0);
        plan(0, 0);
        reset_run("s5");
        run_out("s5", 2000);
        check("s5_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac_config_seq.md
AC_CONFIG_SEQ -- requirements
Module: ac_config_seq

Interface
REQ-001 SHALL have parameter CLK_MASTER_FRQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter PWRUP_DELAY_US, default 1000, meaning wait in µs after reset or start before the first I2C transfer.
REQ-003 SHALL have parameter DEV_ADR, default 8'h34, meaning codec I2C write address byte.
REQ-004 SHALL have parameter INTERFACE_TYPE, default "LEFT-JUSTIFIED", meaning audio format ("LEFT-JUSTIFIED", "RIGHT-JUSTIFIED", "I2S").
REQ-005 SHALL have parameter DATA_WDT, default 24, meaning codec word length (16, 20, 24, 32).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is synchronous to it.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that restarts the whole sequence.
REQ-009 SHALL have port busy, output, 1, high while the sequence runs.
REQ-010 SHALL have port done, output, 1, held high after all entries are written.
REQ-011 SHALL have port error, output, 1, held high after an aborted sequence.
REQ-012 SHALL have port errIdx, output, 4, index of the failing entry.
REQ-013 SHALL have the Avalon-MM master ports avmAdr (output, 2), avmWr (output, 1), avmWrData (output, 8), avmRd (output, 1) and avmRdData (input, 8), which connect to the i2cMaster slave.

Function
REQ-014 SHALL use this i2cMaster map: adr 0 = device byte, adr 1 = data byte high, adr 2 = data byte low, adr 3 write bit0 = go, adr 3 read bit0 = busy and bit1 = nack; read data valid 1 cycle after avmRd.
REQ-015 SHALL hold a 10-entry ROM of {reg[6:0], val[8:0]}: (15,0x000) (0,0x017) (1,0x017) (2,0x079) (3,0x079) (4,0x012) (5,0x000) (6,0x002) (7,FMT) (8,0x000), followed by a final activate write (9,0x001) as entry index 10.
REQ-016 SHALL compute FMT = {IWL,FORMAT} with FORMAT = 00 for right-justified, 01 for left-justified, 10 for I2S, and IWL = 00/01/10/11 for word length 16/20/24/32; with the defaults FMT = 0x009.
REQ-017 SHALL form byte high = {reg, val[8]} and byte low = val[7:0].
REQ-018 SHALL use FSM states IDLE → WAIT_PWR → LD_DEV → LD_HI → LD_LO → GO → POLL_RD → POLL_CHK → (NEXT | ERROR); NEXT leads to LD_DEV, or to DONE after entry 10.
REQ-019 SHALL count ceil(CLK_MASTER_FRQ/1e6 × PWRUP_DELAY_US) cycles in WAIT_PWR.
REQ-020 SHALL spend exactly 1 cycle in each of LD_DEV, LD_HI, LD_LO and GO, each asserting avmWr with the matching avmAdr and avmWrData (GO writes 0x01 to adr 3).
REQ-021 SHALL assert avmRd to adr 3 for 1 cycle in POLL_RD and sample avmRdData in POLL_CHK.
REQ-022 SHALL return from POLL_CHK to POLL_RD while busy=1.
REQ-023 SHALL go from POLL_CHK to NEXT when busy=0 and nack=0.
REQ-024 SHALL treat busy=0 with nack=1 as a failure handled per REQ-033/REQ-034.
REQ-025 SHALL never assert avmWr and avmRd in the same cycle, and SHALL hold both low outside the states above.
REQ-026 SHALL set busy=1 in every state except IDLE, DONE and ERROR.
REQ-027 SHALL respond to start in IDLE, DONE or ERROR by clearing done, error and errIdx, resetting the entry index to 0 and entering WAIT_PWR.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL guard the entry index against running past 10; on wrap it goes to DONE.

Reset
REQ-030 SHALL, on reset, drive busy=0, done=0, error=0, errIdx=0, avmWr=0, avmRd=0, avmAdr=0, avmWrData=0, entry index 0 and delay counter 0.
REQ-031 SHALL leave reset in WAIT_PWR, so configuration starts automatically without a start pulse.
REQ-032 SHALL abort any transfer in progress when reset is asserted mid-sequence, with no further Avalon accesses until reset is released.

Configuration
REQ-033 SHALL, with AC_CONFIG_RETRY_EN defined, retry a NACKed entry from LD_DEV up to 3 times, then enter ERROR with errIdx set to the entry index.
REQ-034 SHALL, without AC_CONFIG_RETRY_EN, go from the first NACK directly to ERROR, with errIdx set to the entry index.

Verification
REQ-035 SHALL verify: reset released, slave always acks, defaults → 33 writes plus polls; entry 8 writes 0x0E then 0x09; done=1 and busy=0 at the end.
REQ-036 SHALL verify: PWRUP_DELAY_US=2 at 50 MHz → first avmWr exactly 100 cycles after reset is released.
REQ-037 SHALL verify: slave reports busy for 5 polls per entry → 5 POLL_RD/POLL_CHK loops per entry, with no extra writes.
REQ-038 SHALL verify: NACK on entry 4 → ERROR with errIdx=4 when AC_CONFIG_RETRY_EN is not defined; when it is defined, 4 attempts are made before ERROR.
REQ-039 SHALL verify: start pulsed while busy → ignored; start pulsed in DONE → done=0 and the sequence reruns from entry 0.
REQ-040 SHALL verify: INTERFACE_TYPE="I2S", DATA_WDT=16 → entry 8 byte low = 0x02; reset asserted mid-POLL → all outputs return to reset values on the next cycle.
